// File: rtl/ecc_pkg.sv
// ecc_pkg: shared widths, error-code encoding and column map for the 20/6 SEC-DED code.
// Code layout: extended Hamming. Check bits parity[4:0] sit at positions 1,2,4,8,16,
// data bits fill the remaining positions 3..25 in ascending order, and parity[5] is the
// overall parity over data and parity[4:0].
package ecc_pkg;

    localparam int DATA_W  = 20;
    localparam int PAR_W   = 6;
    localparam int MAX_POS = 25;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_SBIT = 2'b01,
        ERR_DBIT = 2'b10
    } ecc_err_e;

    localparam logic [4:0] DATA_POS [DATA_W] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14,
        5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25
    };

    // Hamming syndrome contribution of the data bits alone.
    function automatic logic [4:0] data_syn(input logic [DATA_W-1:0] d);
        data_syn = '0;
        for (int i = 0; i < DATA_W; i++)
            data_syn = data_syn ^ (d[i] ? DATA_POS[i] : 5'd0);
    endfunction

    // Check bits for a clean codeword.
    function automatic logic [PAR_W-1:0] ecc_encode(input logic [DATA_W-1:0] d);
        logic [4:0] h;
        h = data_syn(d);
        ecc_encode = {^{d, h}, h};
    endfunction

endpackage

// File: rtl/ecc_20_rd_stage_if.sv
// ecc_20_rd_stage_if: read-word input stream and corrected-word output stream.
// slave  : stage side (consumes in_*, produces out_*)
// master : environment side (produces in_*, consumes out_*)
interface ecc_20_rd_stage_if;
    import ecc_pkg::*;

    logic              in_vld;
    logic              in_rdy;
    logic [DATA_W-1:0] in_data;
    logic [PAR_W-1:0]  in_parity;
    logic              bypass;
    logic              out_vld;
    logic              out_rdy;
    logic [DATA_W-1:0] out_data;
    logic              out_sbit_err;
    logic              out_dbit_err;

    modport slave (
        input  in_vld, in_data, in_parity, bypass, out_rdy,
        output in_rdy, out_vld, out_data, out_sbit_err, out_dbit_err
    );

    modport master (
        output in_vld, in_data, in_parity, bypass, out_rdy,
        input  in_rdy, out_vld, out_data, out_sbit_err, out_dbit_err
    );

endinterface

// File: rtl/ecc_20_top.sv
// ecc_20_top: combinational 20/6 SEC-DED decoder.
// data_in/parity_in : raw word and stored check bits
// data_out          : corrected data (unchanged unless a data bit is fixed)
// err               : ERR_NONE / ERR_SBIT / ERR_DBIT
module ecc_20_top
    import ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [PAR_W-1:0]  parity_in,
    output logic [DATA_W-1:0] data_out,
    output ecc_err_e          err
);

    logic [4:0] syn;
    logic       ov;

    assign syn = data_syn(data_in) ^ parity_in[4:0];
    assign ov  = ^{data_in, parity_in};

    // Odd overall parity means one flipped bit, unless the syndrome points past the
    // last code position; a zero or power-of-two syndrome is a check-bit error and
    // matches no data column, so the data passes through untouched.
    assign err = ov ? (syn > 5'(MAX_POS) ? ERR_DBIT : ERR_SBIT)
                    : (syn != '0 ? ERR_DBIT : ERR_NONE);

    always_comb begin
        data_out = data_in;
        for (int i = 0; i < DATA_W; i++)
            data_out[i] = data_in[i] ^ (ov && syn == DATA_POS[i]);
    end

endmodule

// File: rtl/ecc_20_rd_stage.sv
// ecc_20_rd_stage: two-register ECC read stage (S1 raw word, S2 decoded word).
// clk, rst_n   : clock, asynchronous active-low reset
// bus (slave)  : in_vld/in_rdy/in_data/in_parity/bypass, out_vld/out_rdy/out_data/out_*_err
// cnt_clr      : synchronous clear of sbit_cnt/dbit_cnt (wins over increment)
// sbit_cnt/dbit_cnt : saturating error counters, built only with ECC20_ERR_CNT_EN defined
// err_irq/irq_clr   : sticky uncorrectable-error flag; a same-cycle set wins over clear
module ecc_20_rd_stage
    import ecc_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ecc_20_rd_stage_if.slave     bus,
    input  logic                 cnt_clr,
    input  logic                 irq_clr,
    output logic [CNT_WIDTH-1:0] sbit_cnt,
    output logic [CNT_WIDTH-1:0] dbit_cnt,
    output logic                 err_irq
);

    logic              s1_vld;
    logic              s1_byp;
    logic [DATA_W-1:0] s1_data;
    logic [PAR_W-1:0]  s1_par;
    logic [DATA_W-1:0] dec_data;
    ecc_err_e          dec_err;
    logic              s2_load;
    logic              in_fire;
    logic              xfer;
    logic              sbit_x;
    logic              dbit_x;

    // in_rdy depends only on registered state and out_rdy, never on in_vld.
    assign s2_load    = !bus.out_vld || bus.out_rdy;
    assign bus.in_rdy = !s1_vld || s2_load;
    assign in_fire    = bus.in_vld && bus.in_rdy;
    assign xfer       = s1_vld && s2_load;
    assign sbit_x     = xfer && !s1_byp && dec_err == ERR_SBIT;
    assign dbit_x     = xfer && !s1_byp && dec_err == ERR_DBIT;

    ecc_20_top u_dec (
        .data_in   (s1_data),
        .parity_in (s1_par),
        .data_out  (dec_data),
        .err       (dec_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_byp  <= 1'b0;
            s1_data <= '0;
            s1_par  <= '0;
        end else begin
            s1_vld <= in_fire || (s1_vld && !s2_load);
            if (in_fire) begin
                s1_byp  <= bus.bypass;
                s1_data <= bus.in_data;
                s1_par  <= bus.in_parity;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_vld      <= 1'b0;
            bus.out_data     <= '0;
            bus.out_sbit_err <= 1'b0;
            bus.out_dbit_err <= 1'b0;
        end else if (s2_load) begin
            bus.out_vld <= s1_vld;
            if (s1_vld) begin
                bus.out_data     <= s1_byp ? s1_data : dec_data;
                bus.out_sbit_err <= sbit_x;
                bus.out_dbit_err <= dbit_x;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_irq <= 1'b0;
        else
            err_irq <= dbit_x || (err_irq && !irq_clr);
    end

`ifdef ECC20_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbit_cnt <= '0;
            dbit_cnt <= '0;
        end else if (cnt_clr) begin
            sbit_cnt <= '0;
            dbit_cnt <= '0;
        end else begin
            if (sbit_x && !(&sbit_cnt))
                sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
            if (dbit_x && !(&dbit_cnt))
                dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
        end
    end
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = cnt_clr;
    assign sbit_cnt       = '0;
    assign dbit_cnt       = '0;
`endif

endmodule

// File: tb/tb_ecc_20_rd_stage.sv
// tb_ecc_20_rd_stage: table-driven and scoreboard bench for ecc_20_rd_stage.
module tb_ecc_20_rd_stage;

    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;
`ifdef ECC20_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [19:0] din;
        logic [5:0]  par;
        logic        byp;
        logic [19:0] exp_data;
        logic        exp_s;
        logic        exp_d;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          irq_clr = 1'b0;
    logic [CW-1:0] sbit_cnt;
    logic [CW-1:0] dbit_cnt;
    logic          err_irq;

    ecc_20_rd_stage_if bus ();

    ecc_20_rd_stage #(.CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cnt_clr  (cnt_clr),
        .irq_clr  (irq_clr),
        .sbit_cnt (sbit_cnt),
        .dbit_cnt (dbit_cnt),
        .err_irq  (err_irq)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          acc = 0;
    int          sb_m = 0;
    int          db_m = 0;
    logic        irq_m = 1'b0;
    logic [21:0] q[$];
    vec_t        vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Independent encoder: walk code positions 1..25, data bits take non-powers of two.
    function automatic logic [5:0] enc(input logic [19:0] d);
        logic [4:0] h = '0;
        int n = 0;
        for (int p = 1; p <= 25; p++)
            if ((p & (p - 1)) != 0) begin
                if (d[n]) h ^= p[4:0];
                n++;
            end
        return {^{d, h}, h};
    endfunction

    function automatic int sat(input int v);
        return v > CMAX ? CMAX : v;
    endfunction

    task automatic model_push(input logic [19:0] ed, input logic es, input logic edd);
        q.push_back({ed, es, edd});
        if (es) sb_m = sat(sb_m + 1);
        if (edd) begin
            db_m = sat(db_m + 1);
            irq_m = 1'b1;
        end
    endtask

    task automatic check_cnts(input string nm);
        chk({nm, "_sbit_cnt"}, 32'(sbit_cnt), CNT_EN ? 32'(sb_m) : 32'd0);
        chk({nm, "_dbit_cnt"}, 32'(dbit_cnt), CNT_EN ? 32'(db_m) : 32'd0);
        chk({nm, "_err_irq"}, 32'(err_irq), 32'(irq_m));
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [19:0] d, input logic [5:0] p, input logic b,
                        input logic [19:0] ed, input logic es, input logic edd);
        int t = 0;
        bus.in_vld = 1'b1;
        bus.in_data = d;
        bus.in_parity = p;
        bus.bypass = b;
        @(negedge clk);
        while (!bus.in_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_rdy) chk("send_in_rdy", 32'(bus.in_rdy), 32'd1);
        else begin
            model_push(ed, es, edd);
            acc++;
        end
        @(posedge clk);
        #1;
        bus.in_vld = 1'b0;
        bus.bypass = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Single word into an empty pipeline, with optional clears aligned to its S1->S2 transfer.
    task automatic timed_word(input logic [19:0] d, input logic [5:0] p, input logic [19:0] ed,
                              input logic es, input logic edd, input logic ci, input logic cc);
        bus.in_vld = 1'b1;
        bus.in_data = d;
        bus.in_parity = p;
        bus.bypass = 1'b0;
        model_push(ed, es, edd);
        @(negedge clk);
        chk("tw_in_rdy", 32'(bus.in_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.in_vld = 1'b0;
        irq_clr = ci;
        cnt_clr = cc;
        @(negedge clk);
        chk("lat_no_early_vld", 32'(bus.out_vld), 32'd0);
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        cnt_clr = 1'b0;
        if (cc) begin
            sb_m = 0;
            db_m = 0;
        end
        if (ci && !edd) irq_m = 1'b0;
        @(negedge clk);
        chk("lat_2cyc_vld", 32'(bus.out_vld), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every handshake and checks stalled outputs hold.
    logic        prev_hold = 1'b0;
    logic [21:0] prev_val = '0;
    always @(negedge clk) begin
        if (!rst_n) prev_hold = 1'b0;
        else begin
            if (prev_hold)
                chk("stall_hold", 32'({bus.out_data, bus.out_sbit_err, bus.out_dbit_err}), 32'(prev_val));
            if (bus.out_vld && bus.out_rdy) begin
                if (q.size() == 0) chk("unexpected_out_vld", 32'(bus.out_vld), 32'd0);
                else chk("out_word", 32'({bus.out_data, bus.out_sbit_err, bus.out_dbit_err}),
                         32'(q.pop_front()));
            end
            prev_hold = bus.out_vld && !bus.out_rdy;
            prev_val = {bus.out_data, bus.out_sbit_err, bus.out_dbit_err};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] d;
        logic [19:0] e;
        logic [5:0]  p;
        int          r1;
        int          r2;
        logic        seen;
        vecs[0] = '{20'h00000, 6'h00, 1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[1] = '{20'h00001, 6'h00, 1'b0, 20'h00000, 1'b1, 1'b0};
        vecs[2] = '{20'h00003, 6'h00, 1'b0, 20'h00003, 1'b0, 1'b1};
        vecs[3] = '{20'h00003, 6'h00, 1'b1, 20'h00003, 1'b0, 1'b0};
        for (int k = 4; k < 16; k++) begin
            d = 20'($urandom);
            p = enc(d);
            r1 = $urandom_range(19, 0);
            r2 = (r1 + 1 + $urandom_range(18, 0)) % 20;
            e = d;
            case (k % 4)
                0: vecs[k] = '{d, p, 1'b0, d, 1'b0, 1'b0};
                1: begin e[r1] = ~e[r1]; vecs[k] = '{e, p, 1'b0, d, 1'b1, 1'b0}; end
                2: begin p[r1 % 6] = ~p[r1 % 6]; vecs[k] = '{d, p, 1'b0, d, 1'b1, 1'b0}; end
                default: begin e[r1] = ~e[r1]; e[r2] = ~e[r2]; vecs[k] = '{e, p, 1'b0, e, 1'b0, 1'b1}; end
            endcase
        end
        bus.in_vld = 1'b0;
        bus.in_data = '0;
        bus.in_parity = '0;
        bus.bypass = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_flags", 32'({bus.out_sbit_err, bus.out_dbit_err}), 32'd0);
        check_cnts("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        @(posedge clk);
        #1;

        timed_word(20'h00000, 6'h00, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0);
        timed_word(20'h00001, 6'h00, 20'h00000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_cnts("sbit_one");
        timed_word(20'h00003, 6'h00, 20'h00003, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_cnts("dbit_sticky");
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        irq_m = 1'b0;
        chk("irq_cleared", 32'(err_irq), 32'd0);
        send(20'h00003, 6'h00, 1'b1, 20'h00003, 1'b0, 1'b0);
        drain();
        check_cnts("bypass_no_effect");

        for (int k = 0; k < 16; k++)
            send(vecs[k].din, vecs[k].par, vecs[k].byp, vecs[k].exp_data, vecs[k].exp_s, vecs[k].exp_d);
        drain();
        check_cnts("table");

        bus.out_rdy = 1'b0;
        acc = 0;
        fork
            for (int i = 0; i < 6; i++) begin
                d = 20'h01000 * 20'(i) + 20'(i);
                e = d;
                if (i % 2 == 1) e[i] = ~e[i];
                send(e, enc(d), 1'b0, d, i % 2 == 1, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_accepted", 32'(acc), 32'd2);
                chk("bp_in_rdy_low", 32'(bus.in_rdy), 32'd0);
                @(posedge clk);
                #1;
                bus.out_rdy = 1'b1;
            end
        join
        drain();
        check_cnts("backpressure");

        for (int i = 0; i < 300; i++) send(20'h00001, 6'h00, 1'b0, 20'h00000, 1'b1, 1'b0);
        drain();
        chk("sat_sbit_ff", 32'(sbit_cnt), CNT_EN ? 32'hFF : 32'd0);
        timed_word(20'h00001, 6'h00, 20'h00000, 1'b1, 1'b0, 1'b0, 1'b1);
        check_cnts("cnt_clr_wins");
        timed_word(20'h00003, 6'h00, 20'h00003, 1'b0, 1'b1, 1'b1, 1'b0);
        check_cnts("irq_set_wins");

        bus.out_rdy = 1'b0;
        send(20'h12345, enc(20'h12345), 1'b0, 20'h12345, 1'b0, 1'b0);
        send(20'h0ABCD, enc(20'h0ABCD), 1'b0, 20'h0ABCD, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("midrst_out_data", 32'(bus.out_data), 32'd0);
        q.delete();
        sb_m = 0;
        db_m = 0;
        irq_m = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_rdy = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= bus.out_vld;
        end
        chk("midrst_no_output", 32'(seen), 32'd0);
        chk("midrst_in_rdy", 32'(bus.in_rdy), 32'd1);
        check_cnts("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
